acc_exec_unit: RTL and testbench
================================

# acc_exec_unit

Parametrised accumulator execution unit for the basic-computer datapath. It owns the AC register and E flag and executes memory-reference ops (AND, ADD, LDA) and register-reference ops (CLA…HLT) through a start/operand/done handshake. A small FSM replaces the externally supplied T-phase decode, so the sequencer only issues instructions and supplies operands.

## Interface
- `WIDTH`, 16, AC/operand width in bits; legal range ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  instruction strobe; sampled only in IDLE.
- `mem_ref`  in  1  1 = memory-reference op, 0 = register-reference op; sampled with `start`.
- `opcode`  in  3  memory-reference op: 0 AND, 1 ADD, 2 LDA, 3–7 no-op.
- `rr`  in  12  register-reference field: [11] CLA, [10] CLE, [9] CMA, [8] CME, [7] CIR, [6] CIL, [5] INC, [4] SPA, [3] SNA, [2] SZA, [1] SZE, [0] HLT.
- `opd_req`  out  1  operand request; high throughout WAIT.
- `opd_valid`  in  1  operand present on `opd_data`.
- `opd_data`  in  WIDTH  operand (DR) value.
- `busy`  out  1  high in WAIT, EXEC, DONE.
- `done`  out  1  one-cycle completion pulse.
- `skip`  out  1  skip result; valid only while `done` = 1, else 0.
- `halt`  out  1  sticky halt flag.
- `ac`  out  WIDTH  accumulator.
- `e`  out  1  E (carry/link) flag.

## Operation
- States: IDLE, WAIT, EXEC, DONE.
- IDLE: if `start` & !`halt`, latch `mem_ref`, `opcode`, `rr`; go to WAIT if `mem_ref`, else EXEC. Otherwise `start` is ignored.
- WAIT: `opd_req` = 1. On `opd_valid`, latch DR <= `opd_data` and go to EXEC. Wait indefinitely otherwise.
- EXEC: AC/E/skip/halt update on the exiting edge; go to DONE.
- DONE: `done` = 1 and `skip` valid; new `ac`/`e` visible. Go to IDLE. `start` in DONE is ignored, not queued.
- Memory-reference ops:
  - AND: AC <= AC & DR.
  - ADD: {E,AC} <= AC + DR, with the carry-out of bit WIDTH-1 into E.
  - LDA: AC <= DR.
  - Opcodes 3–7: AC/E unchanged; `done` still pulses.
- Register-reference ops: bits combine, applied as one chain in EXEC:
  - CLA/CLE clear AC/E.
  - CMA/CME complement the result.
  - INC adds 1 to AC modulo 2^WIDTH; E is not affected (0xFFFF → 0x0000).
  - CIR: AC <= {E, AC[W-1:1]}, E <= AC[0].
  - CIL: AC <= {AC[W-2:0], E}, E <= AC[W-1].
  - CIR and CIL both set: no rotation.
- Skip tests evaluate the pre-execution AC/E:
  - SPA: AC[W-1] = 0. SNA: AC[W-1] = 1. SZA: AC = 0. SZE: E = 0.
  - `skip` = OR of the enabled tests.
- HLT sets `halt`; `halt` stays set until `rst` and blocks `start`.
- `opd_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `ac` = 0, `e` = 0, `halt` = 0, `done` = 0, `skip` = 0, `opd_req` = 0, `busy` = 0; DR = 0.
- Reset is asynchronous: outputs go to reset values immediately, including mid-WAIT/EXEC/DONE. The in-flight instruction is discarded with no `done`.
- Register-reference: `start` sampled at edge n; EXEC in cycle n+1; `done` in cycle n+2; next `start` accepted at edge n+3.
- Memory-reference: `opd_req` high from cycle n+1. If `opd_valid` is sampled at edge m, EXEC is cycle m+1 and `done` is cycle m+2. Minimum latency is 3 cycles from `start` to `done` (`opd_valid` already high in the first WAIT cycle).
- `done` and `skip` are registered, never combinational from inputs. `opd_req` and `busy` decode from state only.

## Configuration
- `ACC_ROTATE_EN`:
  - Defined: CIR/CIL implemented as above.
  - Undefined: `rr[7]`/`rr[6]` ignored; AC/E unaffected by them; all other behaviour identical.

## Test plan
- Reset, then LDA with `opd_data` = 0x00F0 (WIDTH = 16) -> `opd_req` high until `opd_valid`; `done` pulses 2 cycles after `opd_valid`; `ac` = 0x00F0, `e` = 0.
- AC = 0x0001, ADD 0xFFFF -> `ac` = 0x0000, `e` = 1. Then rr = 0x006 (SZA|SZE) -> `skip` = 1 with `done`; AC/E unchanged.
- AC = 0x1234, E = 1, rr = 0xA20 (CLA|CMA|INC) -> `ac` = 0x0000, `e` = 1; register-reference `done` latency is exactly 2 cycles after `start`.
- With `ACC_ROTATE_EN`:
  - AC = 0x8001, E = 0, CIL -> `ac` = 0x0002, `e` = 1.
  - AC = 0x0001, E = 1, CIR -> `ac` = 0x8000, `e` = 1.
  - rr = 0x0C0 (both) -> unchanged.
  - Without the macro: CIL leaves 0x8001 / E = 0 unchanged.
- rr = 0x001 (HLT) -> `halt` = 1. Three further `start` pulses -> `busy` stays 0, no `done`. `rst` -> `halt` = 0.
- ADD issued; `rst` asserted mid-cycle while in WAIT -> `opd_req`/`busy` drop without waiting for a clock edge; `ac` = 0; no `done`; a late `opd_valid` is ignored.

Source files
------------

// File: rtl/acc_exec_unit_if.sv
// Handshake/bus bundle between the instruction sequencer (master) and the
// accumulator execution unit (slave).
interface acc_exec_unit_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             mem_ref;
    logic [2:0]       opcode;
    logic [11:0]      rr;
    logic             opd_req;
    logic             opd_valid;
    logic [WIDTH-1:0] opd_data;
    logic             busy;
    logic             done;
    logic             skip;
    logic             halt;
    logic [WIDTH-1:0] ac;
    logic             e;

    modport master (
        output start, mem_ref, opcode, rr, opd_valid, opd_data,
        input  opd_req, busy, done, skip, halt, ac, e
    );

    modport slave (
        input  start, mem_ref, opcode, rr, opd_valid, opd_data,
        output opd_req, busy, done, skip, halt, ac, e
    );
endinterface

// File: rtl/acc_exec_unit.sv
// Accumulator execution unit: owns AC/E, runs memory- and register-reference ops.
// Optional macro ACC_ROTATE_EN enables the CIR/CIL rotate operations.
//
// state | meaning
// IDLE  | waiting for start (blocked while halted)
// WAIT  | memory-reference op, requesting operand
// EXEC  | AC/E/skip/halt update on the exiting edge
// DONE  | done pulse, skip valid
module acc_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    acc_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             mem_ref_q, mem_ref_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [11:0]      rr_q, rr_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic             e_q, e_d;
    logic             halt_q, halt_d;
    logic             done_q, done_d;
    logic             skip_q, skip_d;

    logic [WIDTH-1:0] rr_ac;
    logic             rr_e;
    logic             skip_hit;
    logic             accept;

    assign accept = bus.start && !halt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mem_ref_q <= 1'b0;
            opcode_q  <= '0;
            rr_q      <= '0;
            dr_q      <= '0;
            ac_q      <= '0;
            e_q       <= 1'b0;
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_ref_q <= mem_ref_d;
            opcode_q  <= opcode_d;
            rr_q      <= rr_d;
            dr_q      <= dr_d;
            ac_q      <= ac_d;
            e_q       <= e_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
            skip_q    <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = bus.mem_ref ? S_WAIT : S_EXEC;
            S_WAIT:  if (bus.opd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register-reference ops applied as one chain on the current AC/E.
    always_comb begin
        rr_ac = ac_q;
        rr_e  = e_q;
        if (rr_q[11]) rr_ac = '0;
        if (rr_q[10]) rr_e  = 1'b0;
        if (rr_q[9])  rr_ac = ~rr_ac;
        if (rr_q[8])  rr_e  = ~rr_e;
`ifdef ACC_ROTATE_EN
        if (rr_q[7] && !rr_q[6])
            {rr_e, rr_ac} = {rr_ac[0], rr_e, rr_ac[WIDTH-1:1]};
        else if (rr_q[6] && !rr_q[7])
            {rr_e, rr_ac} = {rr_ac[WIDTH-1], rr_ac[WIDTH-2:0], rr_e};
`endif
        if (rr_q[5])  rr_ac = rr_ac + 1'b1;
    end

`ifndef ACC_ROTATE_EN
    logic unused_rot;
    assign unused_rot = ^rr_q[7:6];
`endif

    // Skip tests look at AC/E before this instruction modifies them.
    assign skip_hit = (rr_q[4] && !ac_q[WIDTH-1]) ||
                      (rr_q[3] &&  ac_q[WIDTH-1]) ||
                      (rr_q[2] &&  (ac_q == '0))  ||
                      (rr_q[1] && !e_q);

    always_comb begin
        mem_ref_d = mem_ref_q;
        opcode_d  = opcode_q;
        rr_d      = rr_q;
        dr_d      = dr_q;
        ac_d      = ac_q;
        e_d       = e_q;
        halt_d    = halt_q;
        done_d    = (state_q == S_EXEC);
        skip_d    = 1'b0;

        if (state_q == S_IDLE && accept) begin
            mem_ref_d = bus.mem_ref;
            opcode_d  = bus.opcode;
            rr_d      = bus.rr;
        end

        if (state_q == S_WAIT && bus.opd_valid)
            dr_d = bus.opd_data;

        if (state_q == S_EXEC) begin
            if (mem_ref_q) begin
                case (opcode_q)
                    3'd0:    ac_d = ac_q & dr_q;
                    3'd1:    {e_d, ac_d} = {1'b0, ac_q} + {1'b0, dr_q};
                    3'd2:    ac_d = dr_q;
                    default: ;
                endcase
            end else begin
                ac_d   = rr_ac;
                e_d    = rr_e;
                skip_d = skip_hit;
                if (rr_q[0]) halt_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.opd_req = (state_q == S_WAIT);
        bus.busy    = (state_q != S_IDLE);
        bus.done    = done_q;
        bus.skip    = skip_q;
        bus.halt    = halt_q;
        bus.ac      = ac_q;
        bus.e       = e_q;
    end
endmodule

// File: tb/tb_acc_exec_unit.sv
// Directed bench for acc_exec_unit: expected AC/E/skip queued at issue,
// popped and compared when done pulses.
module tb_acc_exec_unit;
    localparam int W = 16;

    logic clk;
    logic rst;

    acc_exec_unit_if #(.WIDTH(W)) bus ();

    acc_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] ac;
        logic         e;
        logic         skip;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input string tag);
        exp_t x;
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_sb"}, {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_ac"},   {16'b0, bus.ac},   {16'b0, x.ac});
            chk({tag, "_e"},    {31'b0, bus.e},    {31'b0, x.e});
            chk({tag, "_skip"}, {31'b0, bus.skip}, {31'b0, x.skip});
        end
    endtask

    task automatic rr_op(input logic [11:0] rrv, input logic [W-1:0] eac,
                         input logic ee, input logic esk, input string tag);
        sb.push_back('{ac: eac, e: ee, skip: esk});
        @(negedge clk);
        bus.start = 1'b1; bus.mem_ref = 1'b0; bus.rr = rrv;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_exec_done"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_exec_skip"}, {31'b0, bus.skip}, 32'd0);
        @(negedge clk);
        collect(tag);
        @(negedge clk);
        chk({tag, "_post_done"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_post_busy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic mem_op(input logic [2:0] opc, input logic [W-1:0] data, input int wait_cyc,
                          input logic [W-1:0] eac, input logic ee, input string tag);
        sb.push_back('{ac: eac, e: ee, skip: 1'b0});
        @(negedge clk);
        bus.start = 1'b1; bus.mem_ref = 1'b1; bus.opcode = opc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            chk({tag, "_req_wait"}, {31'b0, bus.opd_req}, 32'd1);
            @(negedge clk);
        end
        chk({tag, "_req"}, {31'b0, bus.opd_req}, 32'd1);
        bus.opd_valid = 1'b1; bus.opd_data = data;
        @(negedge clk);
        bus.opd_valid = 1'b0; bus.opd_data = '0;
        chk({tag, "_exec_req"},  {31'b0, bus.opd_req}, 32'd0);
        chk({tag, "_exec_done"}, {31'b0, bus.done},    32'd0);
        @(negedge clk);
        collect(tag);
        @(negedge clk);
        chk({tag, "_post_done"}, {31'b0, bus.done}, 32'd0);
    endtask

    logic [W-1:0] rot_ac;
    logic         rot_e;

    initial begin
        bus.start = 1'b0; bus.mem_ref = 1'b0; bus.opcode = '0; bus.rr = '0;
        bus.opd_valid = 1'b0; bus.opd_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_ac",   {16'b0, bus.ac},        32'd0);
        chk("rst_e",    {31'b0, bus.e},         32'd0);
        chk("rst_halt", {31'b0, bus.halt},      32'd0);
        chk("rst_done", {31'b0, bus.done},      32'd0);
        chk("rst_skip", {31'b0, bus.skip},      32'd0);
        chk("rst_req",  {31'b0, bus.opd_req},   32'd0);
        chk("rst_busy", {31'b0, bus.busy},      32'd0);

        mem_op(3'd2, 16'h00F0, 3, 16'h00F0, 1'b0, "lda_f0");
        mem_op(3'd2, 16'h0001, 0, 16'h0001, 1'b0, "lda_1");
        mem_op(3'd1, 16'hFFFF, 1, 16'h0000, 1'b1, "add_carry");
        rr_op(12'h006, 16'h0000, 1'b1, 1'b1, "sza_sze");
        rr_op(12'h008, 16'h0000, 1'b1, 1'b0, "sna_zero");
        rr_op(12'h010, 16'h0000, 1'b1, 1'b1, "spa_zero");
        mem_op(3'd2, 16'h1234, 0, 16'h1234, 1'b1, "lda_1234");
        rr_op(12'hA20, 16'h0000, 1'b1, 1'b0, "cla_cma_inc");
        mem_op(3'd2, 16'hFF0F, 2, 16'hFF0F, 1'b1, "lda_ff0f");
        mem_op(3'd0, 16'h0FF0, 0, 16'h0F00, 1'b1, "and");
        mem_op(3'd1, 16'h0001, 0, 16'h0F01, 1'b0, "add_nocarry");
        mem_op(3'd5, 16'h1111, 0, 16'h0F01, 1'b0, "nop_opc5");
        mem_op(3'd2, 16'hFFFF, 0, 16'hFFFF, 1'b0, "lda_ffff");
        rr_op(12'h024, 16'h0000, 1'b0, 1'b0, "inc_wrap");

        mem_op(3'd2, 16'h8001, 0, 16'h8001, 1'b0, "lda_8001");
`ifdef ACC_ROTATE_EN
        rr_op(12'h040, 16'h0002, 1'b1, 1'b0, "cil");
        rot_e = 1'b1;
`else
        rr_op(12'h040, 16'h8001, 1'b0, 1'b0, "cil_off");
        rot_e = 1'b0;
`endif
        mem_op(3'd2, 16'h0001, 0, 16'h0001, rot_e, "lda_0001");
        rr_op(12'h500, 16'h0001, 1'b1, 1'b0, "cle_cme");
`ifdef ACC_ROTATE_EN
        rot_ac = 16'h8000;
`else
        rot_ac = 16'h0001;
`endif
        rr_op(12'h080, rot_ac, 1'b1, 1'b0, "cir");
        rr_op(12'h0C0, rot_ac, 1'b1, 1'b0, "cir_cil_both");
        rr_op(12'h002, rot_ac, 1'b1, 1'b0, "sze_e1");

        @(negedge clk);
        bus.opd_valid = 1'b1; bus.opd_data = 16'hAAAA;
        @(negedge clk);
        bus.opd_valid = 1'b0;
        chk("idle_valid_busy", {31'b0, bus.busy}, 32'd0);
        chk("idle_valid_ac",   {16'b0, bus.ac},   {16'b0, rot_ac});

        // start held through EXEC and DONE must not launch a second instruction
        sb.push_back('{ac: rot_ac, e: 1'b0, skip: 1'b0});
        @(negedge clk);
        bus.start = 1'b1; bus.mem_ref = 1'b0; bus.rr = 12'h400;
        @(negedge clk);
        chk("hold_exec_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        collect("hold_start");
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_idle_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("hold_idle_done", {31'b0, bus.done}, 32'd0);

        rr_op(12'h001, rot_ac, 1'b0, 1'b0, "hlt");
        chk("halt_set", {31'b0, bus.halt}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.mem_ref = 1'b0; bus.rr = 12'h020;
            @(negedge clk);
            bus.start = 1'b0;
            chk("halted_busy", {31'b0, bus.busy}, 32'd0);
            @(negedge clk);
            chk("halted_done", {31'b0, bus.done}, 32'd0);
            chk("halted_busy2", {31'b0, bus.busy}, 32'd0);
        end
        chk("halted_ac", {16'b0, bus.ac}, {16'b0, rot_ac});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("halt_clr", {31'b0, bus.halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        mem_op(3'd2, 16'h5555, 0, 16'h5555, 1'b0, "lda_5555");
        @(negedge clk);
        bus.start = 1'b1; bus.mem_ref = 1'b1; bus.opcode = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_req_pre", {31'b0, bus.opd_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req",  {31'b0, bus.opd_req}, 32'd0);
        chk("abort_busy", {31'b0, bus.busy},    32'd0);
        chk("abort_ac",   {16'b0, bus.ac},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.opd_valid = 1'b1; bus.opd_data = 16'h7777;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("late_done", {31'b0, bus.done}, 32'd0);
            chk("late_busy", {31'b0, bus.busy}, 32'd0);
        end
        bus.opd_valid = 1'b0;
        chk("late_ac", {16'b0, bus.ac}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
